isr_tracker: RTL and testbench



---
 rtl/isr_tracker_pkg.sv | 58 +++++
 rtl/isr_tracker_if.sv | 33 +++
 rtl/isr_tracker_z80_bus_sync.sv | 56 +++++
 rtl/isr_tracker.sv | 171 +++++++++++++++++
 tb/tb_isr_tracker.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isr_tracker_pkg.sv
// ============================================================================
// Module   : isr_tracker_pkg
// Purpose  : Shared definitions for the Z80 instruction-boundary tracker:
//            prefix-state encoding, opcode constants, default protected I/O
//            window and the prefix next-state helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package isr_tracker_pkg;

  // Prefix state of the instruction currently being fetched.
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,   // at an instruction boundary
    ST_CB   = 2'd1,   // CB prefix seen
    ST_ED   = 2'd2,   // ED prefix seen
    ST_IDX  = 2'd3    // DD/FD index prefix seen
  } prefix_state_t;

  localparam int          c_bus_w       = 8;

  localparam logic [7:0]  c_op_cb       = 8'hCB;
  localparam logic [7:0]  c_op_ed       = 8'hED;
  localparam logic [7:0]  c_op_dd       = 8'hDD;
  localparam logic [7:0]  c_op_fd       = 8'hFD;
  localparam logic [7:0]  c_op_retn     = 8'h45;  // second byte of ED 45
  localparam logic [7:0]  c_op_jp       = 8'hC3;

  localparam logic [7:0]  c_io_prot_base_dflt = 8'h40;
  localparam logic [7:0]  c_io_prot_mask_dflt = 8'hF0;

  // Next prefix state after an M1 fetch of 'op' from state 'cur'.
  // Returning ST_NONE means the fetch completed an instruction.
  function automatic prefix_state_t next_prefix(input prefix_state_t cur,
                                                input logic [7:0]    op);
    prefix_state_t nxt;
    nxt = ST_NONE;
    unique case (cur)
      ST_NONE: begin
        if (op == c_op_cb)                         nxt = ST_CB;
        else if (op == c_op_ed)                    nxt = ST_ED;
        else if ((op == c_op_dd) || (op == c_op_fd)) nxt = ST_IDX;
      end
      ST_IDX: begin
        // DD/FD CB: displacement and final opcode are non-M1 reads, so the
        // CB fetch is the last M1 of the instruction.
        if ((op == c_op_dd) || (op == c_op_fd))    nxt = ST_IDX;
        else if (op == c_op_ed)                    nxt = ST_ED;
      end
      default: nxt = ST_NONE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isr_tracker_if.sv
// ============================================================================
// Module   : isr_tracker_if
// Purpose  : Raw Z80 bus bundle observed by the tracker.
// Ports    : m1_n, mreq_n, iorq_n, rd_n  - raw active-low control strobes
//            addr_lo[7:0]                - Z80 A7..A0
//            data[7:0]                   - Z80 D7..D0
//            modport master drives the bus (CPU side / bench),
//            modport slave observes it (tracker).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface isr_tracker_if;
  import isr_tracker_pkg::*;

  logic               m1_n;
  logic               mreq_n;
  logic               iorq_n;
  logic               rd_n;
  logic [c_bus_w-1:0] addr_lo;
  logic [c_bus_w-1:0] data;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, addr_lo, data
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, addr_lo, data
  );

endinterface

`default_nettype wire

// File: rtl/isr_tracker_z80_bus_sync.sv
// ============================================================================
// Module   : z80_bus_sync
// Purpose  : Synchronizes the asynchronous Z80 strobes into clk and delays
//            addr_lo/data by the same depth so they stay aligned with them.
// Ports    : clk, rst                 - system clock, sync active-high reset
//            bus (slave)              - raw Z80 bus
//            sync_m1_n/mreq_n/iorq_n/rd_n - synchronized strobes
//            sync_addr_lo, sync_data  - aligned address / data
// Params   : SYNC_STAGES - flop depth (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bus_sync
  import isr_tracker_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  isr_tracker_if.slave       bus,
  output logic               sync_m1_n,
  output logic               sync_mreq_n,
  output logic               sync_iorq_n,
  output logic               sync_rd_n,
  output logic [c_bus_w-1:0] sync_addr_lo,
  output logic [c_bus_w-1:0] sync_data
);

  // Strobe stages packed as {m1_n, mreq_n, iorq_n, rd_n}; bus stages as
  // {addr_lo, data}. Stage SYNC_STAGES-1 is the aligned output.
  logic [3:0]           r_strobe [SYNC_STAGES];
  logic [2*c_bus_w-1:0] r_bus    [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_strobe[i] <= 4'b1111;
        r_bus[i]    <= '0;
      end
    end else begin
      r_strobe[0] <= {bus.m1_n, bus.mreq_n, bus.iorq_n, bus.rd_n};
      r_bus[0]    <= {bus.addr_lo, bus.data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_strobe[i] <= r_strobe[i-1];
        r_bus[i]    <= r_bus[i-1];
      end
    end
  end

  assign {sync_m1_n, sync_mreq_n, sync_iorq_n, sync_rd_n} = r_strobe[SYNC_STAGES-1];
  assign {sync_addr_lo, sync_data}                        = r_bus[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/isr_tracker.sv
// ============================================================================
// Module   : isr_tracker
// Purpose  : Z80 bus observer. Follows M1 fetches through CB/ED/DD/FD prefix
//            sequences to qualify instruction boundaries for trap entry/exit,
//            and flags I/O accesses to a protected port window while
//            virtualization is active outside a trap.
// Ports    : clk, rst          - system clock (>= 4x Z80 clock), sync reset
//            bus (slave)       - raw Z80 bus (m1_n, mreq_n, iorq_n, rd_n,
//                                addr_lo, data)
//            virtual_enabled   - virtualization active
//            trap_state        - trap in progress
//            new_isr           - next M1 starts a fresh instruction
//            last_isr_untrap   - last completed instruction was an untrap
//            io_violation      - protected I/O cycle in progress
//            last_opcode[7:0]  - last captured M1 opcode
// Config   : ISR_TRACKER_UNTRAP_JP_EN - when defined, an unprefixed C3
//            (JP nn) also counts as an untrap instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isr_tracker
  import isr_tracker_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] IO_PROT_BASE = c_io_prot_base_dflt,
  parameter logic [7:0] IO_PROT_MASK = c_io_prot_mask_dflt
) (
  input  logic               clk,
  input  logic               rst,
  isr_tracker_if.slave       bus,
  input  logic               virtual_enabled,
  input  logic               trap_state,
  output logic               new_isr,
  output logic               last_isr_untrap,
  output logic               io_violation,
  output logic [c_bus_w-1:0] last_opcode
);

  localparam int c_flush_w = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);

  logic               w_m1_n, w_mreq_n, w_iorq_n, w_rd_n;
  logic [c_bus_w-1:0] w_addr_lo, w_data;

  z80_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sync_m1_n    (w_m1_n),
    .sync_mreq_n  (w_mreq_n),
    .sync_iorq_n  (w_iorq_n),
    .sync_rd_n    (w_rd_n),
    .sync_addr_lo (w_addr_lo),
    .sync_data    (w_data)
  );

  // Previous-clock copies. M1 and MREQ are taken from the clock before the
  // RD rising edge so a CPU releasing M1/MREQ together with RD still counts.
  logic               r_rd_n_prev, r_m1_n_prev, r_mreq_n_prev;
  logic [c_bus_w-1:0] r_data_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_n_prev   <= 1'b1;
      r_m1_n_prev   <= 1'b1;
      r_mreq_n_prev <= 1'b1;
      r_data_prev   <= '0;
    end else begin
      r_rd_n_prev   <= w_rd_n;
      r_m1_n_prev   <= w_m1_n;
      r_mreq_n_prev <= w_mreq_n;
      r_data_prev   <= w_data;
    end
  end

  logic w_intack;
  logic w_fetch_end;

  assign w_intack    = ~w_m1_n & ~w_iorq_n;
  assign w_fetch_end = w_rd_n & ~r_rd_n_prev & ~r_m1_n_prev & ~r_mreq_n_prev & ~w_intack;

  // --------------------------------------------------------------------------
  // Prefix FSM with registered qualifiers
  // --------------------------------------------------------------------------
  prefix_state_t      r_state;
  prefix_state_t      w_next_state;
  logic               w_untrap_retn;
  logic               w_untrap_jp;
  logic               r_new_isr;
  logic               r_untrap;
  logic [c_bus_w-1:0] r_last_opcode;

  assign w_next_state  = next_prefix(r_state, r_data_prev);
  assign w_untrap_retn = (r_state == ST_ED) && (r_data_prev == c_op_retn);

`ifdef ISR_TRACKER_UNTRAP_JP_EN
  assign w_untrap_jp   = (r_state == ST_NONE) && (r_data_prev == c_op_jp);
`else
  assign w_untrap_jp   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_NONE;
      r_new_isr     <= 1'b1;
      r_untrap      <= 1'b0;
      r_last_opcode <= '0;
    end else if (w_intack) begin
      r_state       <= ST_NONE;
      r_new_isr     <= 1'b1;
      r_untrap      <= 1'b0;
    end else if (w_fetch_end) begin
      r_state       <= w_next_state;
      r_new_isr     <= (w_next_state == ST_NONE);
      r_last_opcode <= r_data_prev;
      // Only a completing fetch reports; prefix bytes keep the old verdict.
      if (w_next_state == ST_NONE) begin
        r_untrap    <= w_untrap_retn | w_untrap_jp;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Protected I/O window
  // --------------------------------------------------------------------------
  // After reset the synchronizer still shows idle strobes for SYNC_STAGES
  // clocks. Flagging is armed only once IORQ has been seen high on a fully
  // refreshed pipeline, so a cycle already running at reset release is
  // ignored.
  logic [c_flush_w-1:0] r_flush_cnt;
  logic                 w_flushed;
  logic                 r_io_armed;
  logic                 r_io_violation;
  logic                 w_io_hit;

  assign w_flushed = (r_flush_cnt == c_flush_w'(SYNC_STAGES));
  assign w_io_hit  = r_io_armed & ~w_iorq_n & w_m1_n
                   & ((w_addr_lo & IO_PROT_MASK) == (IO_PROT_BASE & IO_PROT_MASK))
                   & virtual_enabled & ~trap_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt    <= '0;
      r_io_armed     <= 1'b0;
      r_io_violation <= 1'b0;
    end else begin
      if (!w_flushed) begin
        r_flush_cnt  <= r_flush_cnt + c_flush_w'(1);
      end
      if (w_flushed && w_iorq_n) begin
        r_io_armed   <= 1'b1;
      end
      // Once set, the flag ignores trap/virtual changes until IORQ ends.
      if (w_iorq_n) begin
        r_io_violation <= 1'b0;
      end else if (w_io_hit) begin
        r_io_violation <= 1'b1;
      end
    end
  end

  assign new_isr         = r_new_isr;
  assign last_isr_untrap = r_untrap;
  assign io_violation    = r_io_violation;
  assign last_opcode     = r_last_opcode;

endmodule

`default_nettype wire

// File: tb/tb_isr_tracker.sv
// ============================================================================
// Module   : tb_isr_tracker
// Purpose  : Self-checking bench for isr_tracker. Drives directed Z80 bus
//            cycles, keeps an instruction-level model (queue of pending
//            prefix bytes) and compares every clock plus literal checkpoints.
// Config   : honours ISR_TRACKER_UNTRAP_JP_EN for the C3 expectation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isr_tracker;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;   // raw edge to output, in clocks

`ifdef ISR_TRACKER_UNTRAP_JP_EN
  localparam bit JP_EN = 1'b1;
`else
  localparam bit JP_EN = 1'b0;
`endif

  logic       clk             = 1'b0;
  logic       rst             = 1'b1;
  logic       virtual_enabled = 1'b0;
  logic       trap_state      = 1'b0;
  logic       new_isr;
  logic       last_isr_untrap;
  logic       io_violation;
  logic [7:0] last_opcode;

  int tests    = 0;
  int fails    = 0;
  bit checking = 1'b0;

  isr_tracker_if bus_if ();

  isr_tracker #(
    .SYNC_STAGES  (SYNC),
    .IO_PROT_BASE (8'h40),
    .IO_PROT_MASK (8'hF0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if.slave),
    .virtual_enabled (virtual_enabled),
    .trap_state      (trap_state),
    .new_isr         (new_isr),
    .last_isr_untrap (last_isr_untrap),
    .io_violation    (io_violation),
    .last_opcode     (last_opcode)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    check(name, {7'd0, act}, {7'd0, exp});
  endtask

  // --------------------------------------------------------------------------
  // Instruction-level model: pending prefix bytes of the current instruction.
  // --------------------------------------------------------------------------
  logic [7:0] m_pend[$];
  logic       m_new_isr = 1'b1;
  logic       m_untrap  = 1'b0;
  logic       m_io      = 1'b0;
  logic [7:0] m_last_op = 8'h00;

  function automatic bit is_prefix_any(input logic [7:0] b);
    return (b == 8'hCB) || (b == 8'hED) || (b == 8'hDD) || (b == 8'hFD);
  endfunction

  function automatic void model_fetch(input logic [7:0] op);
    bit complete;
    bit untrap;
    logic [7:0] last;
    m_last_op = op;
    if (m_pend.size() == 0) begin
      complete = !is_prefix_any(op);
      untrap   = JP_EN && (op == 8'hC3);
    end else begin
      last = m_pend[m_pend.size()-1];
      if ((last == 8'hDD) || (last == 8'hFD)) begin
        complete = !((op == 8'hDD) || (op == 8'hFD) || (op == 8'hED));
        untrap   = 1'b0;
      end else begin
        complete = 1'b1;
        untrap   = (last == 8'hED) && (op == 8'h45);
      end
    end
    if (complete) begin
      m_pend.delete();
      m_untrap = untrap;
    end else begin
      m_pend.push_back(op);
    end
    m_new_isr = (m_pend.size() == 0);
  endfunction

  function automatic void model_reset();
    m_pend.delete();
    m_new_isr = 1'b1;
    m_untrap  = 1'b0;
    m_io      = 1'b0;
    m_last_op = 8'h00;
  endfunction

  // Model outputs delayed by the bus-to-output latency.
  logic [10:0] exp_pipe [LAT];
  logic [10:0] m_cur;
  assign m_cur = {m_new_isr, m_untrap, m_io, m_last_op};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) exp_pipe[i] <= {1'b1, 1'b0, 1'b0, 8'h00};
    end else begin
      exp_pipe[0] <= m_cur;
      for (int i = 1; i < LAT; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk  ("cyc_new_isr",     new_isr,         exp_pipe[LAT-1][10]);
      chk  ("cyc_last_untrap", last_isr_untrap, exp_pipe[LAT-1][9]);
      chk  ("cyc_io_violation",io_violation,    exp_pipe[LAT-1][8]);
      check("cyc_last_opcode", last_opcode,     exp_pipe[LAT-1][7:0]);
    end
  end

  // --------------------------------------------------------------------------
  // Bus cycle tasks (raw signals change on the falling clock edge)
  // --------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus_if.m1_n = 1'b1; bus_if.mreq_n = 1'b1; bus_if.iorq_n = 1'b1;
    bus_if.rd_n = 1'b1; bus_if.addr_lo = 8'h00; bus_if.data = 8'h00;
  endtask

  task automatic fetch(input logic [7:0] op);
    @(negedge clk);
    bus_if.addr_lo = 8'h42; bus_if.data = op;
    bus_if.m1_n = 1'b0; bus_if.mreq_n = 1'b0; bus_if.rd_n = 1'b0;
    idle(4);
    bus_if.rd_n = 1'b1;
    model_fetch(op);
    idle(1);
    bus_if.m1_n = 1'b1; bus_if.mreq_n = 1'b1; bus_if.data = 8'hFF;
    idle(6);
  endtask

  task automatic mem_read(input logic [7:0] b);
    @(negedge clk);
    bus_if.addr_lo = 8'h42; bus_if.data = b;
    bus_if.mreq_n = 1'b0; bus_if.rd_n = 1'b0;
    idle(4);
    bus_if.rd_n = 1'b1; bus_if.mreq_n = 1'b1;
    idle(1);
    bus_if.data = 8'hFF;
    idle(6);
  endtask

  // OUT cycle; exp_flag is the hand-computed flag 3 clocks after IORQ falls.
  task automatic io_cycle(input string name, input logic [7:0] port,
                          input logic exp_flag, input bit trap_mid);
    @(negedge clk);
    bus_if.addr_lo = port; bus_if.data = 8'h5A; bus_if.iorq_n = 1'b0;
    m_io = ((port & 8'hF0) == 8'h40) && virtual_enabled && !trap_state;
    idle(3);
    chk({name, "_set"}, io_violation, exp_flag);
    if (trap_mid) trap_state = 1'b1;
    idle(3);
    chk({name, "_held"}, io_violation, exp_flag);
    bus_if.iorq_n = 1'b1;
    m_io = 1'b0;
    idle(3);
    chk({name, "_clr"}, io_violation, 1'b0);
    idle(3);
  endtask

  task automatic intack();
    @(negedge clk);
    bus_if.m1_n = 1'b0;
    idle(2);
    bus_if.iorq_n = 1'b0;
    m_pend.delete(); m_new_isr = 1'b1; m_untrap = 1'b0;
    idle(4);
    bus_if.m1_n = 1'b1; bus_if.iorq_n = 1'b1;
    idle(6);
  endtask

  task automatic do_reset(input bool_hold_io);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    if (bool_hold_io) begin
      bus_if.addr_lo = 8'h42; bus_if.iorq_n = 1'b0;
    end
    idle(3);
    rst = 1'b0;
  endtask

  typedef bit bool_hold_io_t;

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    bus_idle();
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    checking = 1'b1;
    idle(2);

    // Reset state
    chk  ("reset_new_isr", new_isr, 1'b1);
    chk  ("reset_untrap",  last_isr_untrap, 1'b0);
    chk  ("reset_io",      io_violation, 1'b0);
    check("reset_opcode",  last_opcode, 8'h00);

    // LD A,n then NOP
    fetch(8'h3E);
    check("ld_opcode", last_opcode, 8'h3E);
    chk  ("ld_new_isr", new_isr, 1'b1);
    fetch(8'h00);
    chk  ("nop_new_isr", new_isr, 1'b1);
    chk  ("nop_untrap", last_isr_untrap, 1'b0);
    check("nop_opcode", last_opcode, 8'h00);

    // RETN then NOP
    fetch(8'hED);
    chk  ("ed_new_isr", new_isr, 1'b0);
    fetch(8'h45);
    chk  ("retn_new_isr", new_isr, 1'b1);
    chk  ("retn_untrap", last_isr_untrap, 1'b1);
    check("retn_opcode", last_opcode, 8'h45);
    fetch(8'h00);
    chk  ("after_retn_untrap", last_isr_untrap, 1'b0);

    // DD CB d op: CB is the last M1
    fetch(8'hDD);
    chk  ("ddcb_dd_new_isr", new_isr, 1'b0);
    fetch(8'hCB);
    chk  ("ddcb_cb_new_isr", new_isr, 1'b1);
    mem_read(8'h05);
    mem_read(8'h06);
    check("ddcb_reads_opcode", last_opcode, 8'hCB);
    chk  ("ddcb_reads_new_isr", new_isr, 1'b1);
    fetch(8'h00);
    chk  ("ddcb_next_new_isr", new_isr, 1'b1);
    check("ddcb_next_opcode", last_opcode, 8'h00);

    // Protected I/O window
    virtual_enabled = 1'b1; trap_state = 1'b0;
    io_cycle("io_42", 8'h42, 1'b1, 1'b0);
    io_cycle("io_4f", 8'h4F, 1'b1, 1'b0);
    io_cycle("io_3f", 8'h3F, 1'b0, 1'b0);
    io_cycle("io_52", 8'h52, 1'b0, 1'b0);
    trap_state = 1'b1;
    io_cycle("io_trap", 8'h42, 1'b0, 1'b0);
    trap_state = 1'b0;
    virtual_enabled = 1'b0;
    io_cycle("io_novirt", 8'h42, 1'b0, 1'b0);
    virtual_enabled = 1'b1;
    io_cycle("io_trap_mid", 8'h42, 1'b1, 1'b1);
    trap_state = 1'b0;

    // Interrupt acknowledge abandons the prefix and clears untrap
    fetch(8'hED);
    fetch(8'h45);
    chk  ("pre_ack_untrap", last_isr_untrap, 1'b1);
    fetch(8'hED);
    chk  ("pre_ack_new_isr", new_isr, 1'b0);
    intack();
    chk  ("ack_new_isr", new_isr, 1'b1);
    chk  ("ack_untrap", last_isr_untrap, 1'b0);
    fetch(8'h45);
    chk  ("ack_then_45_untrap", last_isr_untrap, 1'b0);

    // JP nn
    fetch(8'hC3);
    chk  ("jp_untrap", last_isr_untrap, JP_EN);
    fetch(8'hED);
    fetch(8'hC3);
    chk  ("ed_c3_untrap", last_isr_untrap, 1'b0);

    // Index prefix chains
    fetch(8'hDD);
    fetch(8'hED);
    chk  ("dd_ed_new_isr", new_isr, 1'b0);
    fetch(8'h45);
    chk  ("dd_ed_45_untrap", last_isr_untrap, 1'b1);
    fetch(8'hFD);
    fetch(8'hFD);
    chk  ("fd_fd_new_isr", new_isr, 1'b0);
    chk  ("fd_fd_untrap_kept", last_isr_untrap, 1'b1);
    fetch(8'h21);
    chk  ("fd_fd_21_new_isr", new_isr, 1'b1);
    chk  ("fd_fd_21_untrap", last_isr_untrap, 1'b0);
    fetch(8'hCB);
    fetch(8'h7E);
    check("cb_7e_opcode", last_opcode, 8'h7E);
    chk  ("cb_7e_new_isr", new_isr, 1'b1);

    // Reset mid-instruction
    fetch(8'hDD);
    chk  ("mid_rst_pre_new_isr", new_isr, 1'b0);
    do_reset(1'b0);
    idle(2);
    chk  ("mid_rst_new_isr", new_isr, 1'b1);
    check("mid_rst_opcode", last_opcode, 8'h00);
    fetch(8'h00);
    chk  ("mid_rst_next_new_isr", new_isr, 1'b1);

    // I/O cycle already running at reset release is not flagged
    virtual_enabled = 1'b1; trap_state = 1'b0;
    do_reset(1'b1);
    idle(8);
    chk  ("rst_io_not_flagged", io_violation, 1'b0);
    bus_if.iorq_n = 1'b1;
    idle(5);
    io_cycle("io_after_rst", 8'h42, 1'b1, 1'b0);

    idle(LAT + 2);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

endmodule

`default_nettype wire
